mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage MIPS pipeline, between the EXE/MEM pipeline register and write-back. It consumes the memory operation, address and store data produced by the execute stage. It runs each access over a req/ack data bus with variable latency, stalls the pipeline while the access is outstanding, and presents registered write-back results to WB.

## Interface
- TIMEOUT, 255: maximum number of WAIT cycles without `bus_ack` before the access is aborted (1..65535).
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mem_op  input  3  `MEM_NOP_OP` / `MEM_LW_OP` / `MEM_SW_OP` (values from includes/defines.v); other encodings are treated as NOP
- mem_addr  input  32  byte address of the access
- mem_data  input  32  store data
- wr_reg  input  5  destination register from EXE
- wr_data  input  32  ALU/link result from EXE
- we_in  input  1  register write enable from EXE
- bus_rdata  input  32  read data; valid when `bus_ack`=1
- bus_ack  input  1  one-cycle completion strobe from memory/MMIO
- bus_req  output  1  access request; held until ack or abort
- bus_we  output  1  1 = store
- bus_addr  output  32  word-aligned address
- bus_wdata  output  32  store data
- stall  output  1  freezes PC, IF/ID, ID/EXE and EXE/MEM registers
- wb_write_reg  output  5  to WB
- wb_write_data  output  32  to WB
- wb_we  output  1  to WB
- misalign  output  1  sticky; set by an LW/SW with `mem_addr[1:0]`≠0
- bus_err  output  1  sticky; set by a timeout abort

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - An aligned LW/SW at the inputs asserts `stall`=1 combinationally.
  - It latches addr, data, op and wr_reg, then moves to WAIT.
  - Non-memory ops pass through with no stall.
- WAIT:
  - `bus_req`=1; `bus_addr`, `bus_we` and `bus_wdata` are driven from latched values and held stable.
  - `stall`=1.
  - A 16-bit counter increments every WAIT cycle.
  - On `bus_ack`: LW latches `bus_rdata`; SW latches nothing. Go to DONE.
  - If the counter reaches TIMEOUT with no ack: drop the request, load result = 0x00000000, set `bus_err`, go to DONE.
  - If ack and timeout fall in the same cycle, ack wins and `bus_err` is not set.
- DONE:
  - `stall`=0 and `bus_req`=0. The instruction still at the inputs is the completed one and is not re-issued.
  - Go to IDLE at the next edge.
- Write-back register updates at every edge:
  - `stall`=1: load a bubble (reg 0, data 0, we 0).
  - Non-mem op: `wr_reg` / `wr_data` / `we_in`.
  - LW in DONE: `wr_reg` / latched load data / `we_in`.
  - SW in DONE: we 0.
- Misaligned LW/SW:
  - No bus access and no stall; `misalign` is set.
  - The write-back is a bubble (we 0).
- `bus_ack` outside WAIT is ignored.
- Reset:
  - State = IDLE, counter 0.
  - `bus_req`, `bus_we`, `stall`, `wb_we`, `misalign` and `bus_err` are 0.
  - `bus_addr`, `bus_wdata` and `wb_write_data` are 0x00000000; `wb_write_reg`=0.
  - Reset mid-WAIT drops `bus_req` at that edge and discards the access.

## Timing
- Non-memory op: `wb_*` is valid 1 cycle after the op appears at the inputs.
- Memory access, ack in the k-th WAIT cycle (k≥1): the op is stalled in IDLE cycle 0 and WAIT cycles 1..k. DONE is cycle k+1. `wb_*` (LW) is valid after the edge ending DONE, k+2 cycles after issue.
- Minimum LW/SW occupancy is 3 cycles (IDLE, WAIT, DONE).
- Timeout: `bus_req` falls after TIMEOUT WAIT cycles; `bus_err` is visible in the DONE cycle.
- `stall` is combinational from state, `mem_op` and `mem_addr[1:0]`. All other outputs are registered.

## Test plan
- Reset, then ADD result (reg 8, 0x12345678, we 1) at the inputs -> `wb_write_reg`=8 and `wb_write_data`=0x12345678 one cycle later; `stall` never rises.
- LW addr 0x00000010, ack on the 1st WAIT cycle with rdata 0xCAFEF00D, wr_reg 9 -> stall high 2 cycles; `bus_addr`=0x10 and `bus_we`=0; `wb_write_data`=0xCAFEF00D, `wb_write_reg`=9 after DONE.
- SW addr 0x00000020, data 0xA5A5A5A5, ack delayed 5 cycles -> `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` stable for all 5 WAIT cycles; stall high 6 cycles; `wb_we` stays 0.
- LW addr 0x00000013 -> `misalign`=1, `bus_req` never rises, no stall, `wb_we`=0.
- TIMEOUT=4, LW with no ack -> `bus_req` is high exactly 4 cycles; `bus_err`=1 and `wb_write_data`=0; the next instruction then proceeds. A second run with ack on the 4th WAIT cycle -> data is taken and `bus_err` stays 0.
- `rst` asserted on the 2nd WAIT cycle of an LW -> the next cycle shows `bus_req`=0, `stall`=0 and all outputs at reset values; a later ack is ignored.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and memory/MMIO (slave).
// A request is held until the one-cycle ack strobe or an abort.
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_access.sv
// MIPS MEM stage: runs LW/SW over a req/ack bus with variable latency, stalls the
// pipeline while the access is outstanding and registers the write-back result.
module mem_access #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [2:0]  MEM_LW_OP = 3'd1,
    parameter logic [2:0]  MEM_SW_OP = 3'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mem_op,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_data,
    input  logic [4:0]         wr_reg,
    input  logic [31:0]        wr_data,
    input  logic               we_in,
    mem_access_if.master       bus,
    output logic               stall,
    output logic [4:0]         wb_write_reg,
    output logic [31:0]        wb_write_data,
    output logic               wb_we,
    output logic               misalign,
    output logic               bus_err
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        lw_q, lw_d;
    logic [4:0]  reg_q, reg_d;
    logic [31:0] load_q, load_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;

    logic is_lw, is_sw, is_mem, aligned;

    // Any encoding other than LW/SW behaves as NOP.
    assign is_lw   = (mem_op == MEM_LW_OP);
    assign is_sw   = (mem_op == MEM_SW_OP);
    assign is_mem  = is_lw | is_sw;
    assign aligned = (mem_addr[1:0] == 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lw_d      = lw_q;
        reg_d     = reg_q;
        load_d    = load_q;
        mis_d     = mis_q;
        err_d     = err_q;
        stall     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_mem && aligned) begin
                    stall   = 1'b1;
                    state_d = StWait;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_sw;
                    addr_d  = {mem_addr[31:2], 2'b00};
                    wdata_d = mem_data;
                    lw_d    = is_lw;
                    reg_d   = wr_reg;
                end else if (is_mem) begin
                    mis_d = 1'b1;
                end
            end
            StWait: begin
                stall = 1'b1;
                cnt_d = cnt_q + 16'd1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (lw_q) load_d = bus.bus_rdata;
                end else if (cnt_d == 16'(TIMEOUT)) begin
                    req_d   = 1'b0;
                    load_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wb_reg_d  = '0;
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        if (stall) begin
            wb_we_d = 1'b0;
        end else if (state_q == StDone) begin
            // The completed op is still at the inputs; only LW writes back.
            if (lw_q) begin
                wb_reg_d  = reg_q;
                wb_data_d = load_q;
                wb_we_d   = we_in;
            end
        end else if (!is_mem) begin
            wb_reg_d  = wr_reg;
            wb_data_d = wr_data;
            wb_we_d   = we_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lw_q      <= 1'b0;
            reg_q     <= '0;
            load_q    <= '0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lw_q      <= lw_d;
            reg_q     <= reg_d;
            load_q    <= load_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign wb_write_reg  = wb_reg_q;
    assign wb_write_data = wb_data_q;
    assign wb_we         = wb_we_q;
    assign misalign      = mis_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random instruction streams, checked against a
// transaction-level model of stall length, bus occupancy, write-back and sticky flags.
module tb_mem_access;

    localparam int unsigned TO = 4;
    localparam logic [2:0] NOP = 3'd0, LW = 3'd1, SW = 3'd2, ODD = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_data, wr_data;
    logic [4:0]  wr_reg;
    logic        we_in;
    logic        stall, wb_we, misalign, bus_err;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;
    logic exp_mis = 1'b0;

    mem_access_if bus ();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_op        (mem_op),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .we_in         (we_in),
        .bus           (bus.master),
        .stall         (stall),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .wb_we         (wb_we),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_op = NOP;
        we_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_err = 1'b0;
        exp_mis = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".req"}, 32'(bus.bus_req), 0);
        check_eq({tag, ".bwe"}, 32'(bus.bus_we), 0);
        check_eq({tag, ".baddr"}, bus.bus_addr, 0);
        check_eq({tag, ".bwdata"}, bus.bus_wdata, 0);
        check_eq({tag, ".stall"}, 32'(stall), 0);
        check_eq({tag, ".wbwe"}, 32'(wb_we), 0);
        check_eq({tag, ".wbreg"}, 32'(wb_write_reg), 0);
        check_eq({tag, ".wbdata"}, wb_write_data, 0);
        check_eq({tag, ".mis"}, 32'(misalign), 0);
        check_eq({tag, ".err"}, 32'(bus_err), 0);
    endtask

    // lat = WAIT cycle carrying the ack (1-based); 0 means the bus never answers.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic [31:0] wd,
                          input logic we, input int lat, input logic [31:0] rdata);
        bit lw, sw, mem, mis, tmo, done, exp_we;
        int k, n_stall, n_req, cyc;
        lw = (op == LW);
        sw = (op == SW);
        mem = (lw || sw) && (addr[1:0] == 2'b00);
        mis = (lw || sw) && (addr[1:0] != 2'b00);
        tmo = mem && (lat == 0 || lat > int'(TO));
        k = tmo ? int'(TO) : lat;
        n_stall = 0;
        n_req = 0;
        cyc = 0;
        done = 0;
        mem_op = op;
        mem_addr = addr;
        mem_data = data;
        wr_reg = rd;
        wr_data = wd;
        we_in = we;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (bus.bus_req) begin
                n_req++;
                check_eq({tag, ".baddr"}, bus.bus_addr, {addr[31:2], 2'b00});
                check_eq({tag, ".bwe"}, 32'(bus.bus_we), 32'(sw));
                if (sw) check_eq({tag, ".bwdata"}, bus.bus_wdata, data);
                bus.bus_ack = (n_req == lat);
                bus.bus_rdata = bus.bus_ack ? rdata : $urandom;
            end else begin
                // Strobes outside WAIT must be ignored.
                bus.bus_ack = 1'($urandom_range(0, 1));
                bus.bus_rdata = $urandom;
            end
            if (stall) n_stall++;
            else done = 1;
            step();
            bus.bus_ack = 1'b0;
            cyc++;
        end
        check_eq({tag, ".done"}, 32'(done), 1);
        check_eq({tag, ".nstall"}, n_stall, mem ? k + 1 : 0);
        check_eq({tag, ".nreq"}, n_req, mem ? k : 0);
        exp_err = exp_err | tmo;
        exp_mis = exp_mis | mis;
        exp_we = mem ? (lw & we) : (mis ? 1'b0 : we);
        check_eq({tag, ".wbwe"}, 32'(wb_we), 32'(exp_we));
        if (mem && lw) begin
            check_eq({tag, ".wbreg"}, 32'(wb_write_reg), 32'(rd));
            check_eq({tag, ".wbdata"}, wb_write_data, tmo ? 32'h0 : rdata);
        end else if (!mem && !mis) begin
            check_eq({tag, ".wbreg"}, 32'(wb_write_reg), 32'(rd));
            check_eq({tag, ".wbdata"}, wb_write_data, wd);
        end
        check_eq({tag, ".err"}, 32'(bus_err), 32'(exp_err));
        check_eq({tag, ".mis"}, 32'(misalign), 32'(exp_mis));
        check_eq({tag, ".reqafter"}, 32'(bus.bus_req), 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_op = NOP;
        mem_addr = '0;
        mem_data = '0;
        wr_reg = '0;
        wr_data = '0;
        we_in = 1'b0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        do_reset();
        check_idle_outputs("reset");

        run_op("add", NOP, 32'h0, 32'h0, 5'd8, 32'h12345678, 1'b1, 0, 32'h0);
        run_op("lw1", LW, 32'h10, 32'h0, 5'd9, 32'h0, 1'b1, 1, 32'hCAFEF00D);
        run_op("sw5", SW, 32'h20, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5, 32'h0);
        run_op("lwmis", LW, 32'h13, 32'h0, 5'd4, 32'h0, 1'b1, 1, 32'h0);
        run_op("lwto", LW, 32'h30, 32'h0, 5'd7, 32'h0, 1'b1, 0, 32'hDEAD0000);
        run_op("after_to", ODD, 32'h0, 32'h0, 5'd6, 32'h0BADF00D, 1'b1, 0, 32'h0);

        do_reset();
        run_op("lwack4", LW, 32'h44, 32'h0, 5'd10, 32'h0, 1'b1, int'(TO), 32'h600DBEEF);

        // Reset landing in the 2nd WAIT cycle discards the access.
        mem_op = LW;
        mem_addr = 32'h40;
        wr_reg = 5'd3;
        we_in = 1'b1;
        step();
        step();
        rst = 1'b1;
        mem_op = NOP;
        we_in = 1'b0;
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        exp_err = 1'b0;
        exp_mis = 1'b0;
        bus.bus_ack = 1'b1;
        bus.bus_rdata = 32'hFFFFFFFF;
        step();
        bus.bus_ack = 1'b0;
        check_eq("lateack.req", 32'(bus.bus_req), 0);
        check_eq("lateack.stall", 32'(stall), 0);
        check_eq("lateack.wbwe", 32'(wb_we), 0);
        check_eq("lateack.err", 32'(bus_err), 0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            int unsigned r;
            r = $urandom_range(0, 3);
            op = (r == 0) ? NOP : (r == 1) ? LW : (r == 2) ? SW : ODD;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op("rnd", op, a, $urandom, 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), $urandom);
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
